wb_stage: RTL
=============

Name: wb_stage

Overview:
- Parametrised, registered successor to the combinational writeback mux.
- Selects one of NSRC XLEN-bit result sources and formats load data (byte/half/word extraction and sign or zero extension).
- Waits for late memory responses and emits a single-cycle register-file write pulse.
- Sits between the MEM stage and the register file; also serves as the final bypass source.

Parameters:
- XLEN, 32, datapath width (32 or 64).
- NSRC, 4, number of writeback sources (2..8).
- SEL_W, 2, select width; must satisfy 2^SEL_W >= NSRC.
- MEM_IDX, 3, source index that takes formatted load data instead of its io_in_src slice.
- TIMEOUT, 15, maximum cycles spent waiting for io_mem_valid.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- io_in_valid  in  1  writeback request valid
- io_in_ready  out  1  stage can accept a request
- io_in_sel  in  SEL_W  source select
- io_in_src  in  NSRC*XLEN  packed sources; source i at bits [i*XLEN +: XLEN]
- io_in_rd  in  5  destination register
- io_in_rf_wen  in  1  instruction writes rd
- io_ld_type  in  3  load funct3
- io_ld_off  in  log2(XLEN/8)  byte offset of the load address
- io_mem_valid  in  1  memory read data valid
- io_mem_rdata  in  XLEN  memory read data, naturally aligned
- io_wb_wen  out  1  register-file write strobe
- io_wb_rd  out  5  write address
- io_wb_wd  out  XLEN  write data
- io_busy  out  1  load pending (state WAIT)
- io_err_timeout  out  1  single-cycle pulse: memory response timed out
- io_err_ld  out  1  single-cycle pulse: misaligned or illegal load

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: state IDLE, timeout counter 0, all outputs 0 except io_in_ready=1. Reset asserted mid-WAIT drops the pending load with no write and no error pulse.
- States: IDLE, WAIT.
- io_in_ready = (state==IDLE). Accept = io_in_valid & io_in_ready.
- IDLE, accept, sel!=MEM_IDX: register the result. Outputs are valid in the next cycle, so latency is 1.
- IDLE, accept, sel==MEM_IDX, io_mem_valid=1 in the same cycle: format and register the load; latency 1.
- IDLE, accept, sel==MEM_IDX, io_mem_valid=0: latch rd, rf_wen, ld_type and ld_off; go to WAIT; clear the counter.
- WAIT, io_mem_valid=1: format the load, write next cycle, return to IDLE.
  - The write occurs even when the counter equals TIMEOUT-1 in that cycle, because data beats timeout.
- WAIT, io_mem_valid=0: increment the counter. When the counter reaches TIMEOUT, return to IDLE with no write and pulse io_err_timeout next cycle.
- io_mem_valid in IDLE with no MEM accept: ignored.
- io_wb_wen is a one-cycle pulse. It equals the registered rf_wen & (rd!=0) & no load error & sel<NSRC.
- io_wb_rd and io_wb_wd hold their last values between pulses.
- sel>=NSRC: io_wb_wd=0 and wen suppressed; no error.
- Load formatting: extract from io_mem_rdata at byte offset off.
  - 000 LB and 100 LBU: byte, sign or zero extended.
  - 001 LH and 101 LHU: half; off[0] must be 0.
  - 010 LW: word; off[1:0] must be 0; sign extended when XLEN=64.
  - 110 LWU and 011 LD: legal only when XLEN=64. LD requires off==0.
  - 111, and LWU/LD when XLEN=32: illegal.
- Misaligned or illegal load: io_wb_wd=0, wen suppressed, io_err_ld pulses in the output cycle, return to IDLE.
- Non-load sources pass through unmodified; ld_type is ignored for them.

Test Plan:
- XLEN=32, sel=0, src0=0x12345678, rd=5, rf_wen=1 -> next cycle wen=1, rd=5, wd=0x12345678; following cycle wen=0.
- sel=MEM_IDX, LB, off=2, mem_valid same cycle, rdata=0x00800000 -> wd=0xFFFFFF80. Same stimulus with LBU -> wd=0x00000080.
- sel=MEM_IDX, LHU, off=2, mem_valid low for 3 cycles then rdata=0xBEEF0000:
  - busy=1 and in_ready=0 during the wait;
  - wd=0x0000BEEF one cycle after mem_valid.
- LW with off=1 -> wen=0, err_ld=1 for one cycle, wd=0. Separately, rd=0 with a legal source -> wen=0 and no error.
- Load with mem_valid never asserted -> after TIMEOUT=15 waiting cycles, err_timeout pulses, wen=0, in_ready=1. Reset asserted in WAIT -> IDLE next cycle with no pulses.
- XLEN=64, NSRC=6: LW off=4, rdata=0x80000000_00000000 -> wd=0xFFFFFFFF_80000000. sel=7 -> wen=0, wd=0.

Source files
------------

// File: rtl/wb_stage.sv
// Registered writeback stage: selects a result source, formats load data,
// waits for late memory responses and issues a one-cycle register-file write.
module wb_stage #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NSRC    = 4,
    parameter int unsigned SEL_W   = 2,
    parameter int unsigned MEM_IDX = 3,
    parameter int unsigned TIMEOUT = 15,
    localparam int unsigned OFF_W  = $clog2(XLEN / 8),
    localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   io_in_valid,
    output logic                   io_in_ready,
    input  logic [SEL_W-1:0]       io_in_sel,
    input  logic [NSRC*XLEN-1:0]   io_in_src,
    input  logic [4:0]             io_in_rd,
    input  logic                   io_in_rf_wen,
    input  logic [2:0]             io_ld_type,
    input  logic [OFF_W-1:0]       io_ld_off,
    input  logic                   io_mem_valid,
    input  logic [XLEN-1:0]        io_mem_rdata,
    output logic                   io_wb_wen,
    output logic [4:0]             io_wb_rd,
    output logic [XLEN-1:0]        io_wb_wd,
    output logic                   io_busy,
    output logic                   io_err_timeout,
    output logic                   io_err_ld
);

    typedef enum logic {S_IDLE, S_WAIT} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [4:0]         prd_q, prd_d;
    logic               pwen_q, pwen_d;
    logic [2:0]         ptype_q, ptype_d;
    logic [OFF_W-1:0]   poff_q, poff_d;
    logic               wen_q, wen_d;
    logic [4:0]         rd_q, rd_d;
    logic [XLEN-1:0]    wd_q, wd_d;
    logic               err_ld_q, err_ld_d;
    logic               err_to_q, err_to_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;

    logic [XLEN-1:0]    src_val;
    logic               sel_ok;
    logic               is_mem;
    logic               wait_st;
    logic               done_ld;
    logic [2:0]         ld_type_m;
    logic [OFF_W-1:0]   ld_off_m;
    logic [4:0]         rd_m;
    logic               wen_m;
    logic [OFF_W+2:0]   sh_amt;
    logic [7:0]         ld_b;
    logic [15:0]        ld_h;
    logic [31:0]        ld_w;
    logic [XLEN-1:0]    ld_data;
    logic               ld_err;

    assign io_in_ready    = ready_q;
    assign io_busy        = busy_q;
    assign io_wb_wen      = wen_q;
    assign io_wb_rd       = rd_q;
    assign io_wb_wd       = wd_q;
    assign io_err_ld      = err_ld_q;
    assign io_err_timeout = err_to_q;

    assign is_mem  = (io_in_sel == SEL_W'(MEM_IDX));
    assign wait_st = (state_q == S_WAIT);

    // Source mux; selects beyond NSRC leave sel_ok low.
    always_comb begin
        src_val = '0;
        sel_ok  = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (io_in_sel == SEL_W'(i)) begin
                src_val = io_in_src[i*XLEN +: XLEN];
                sel_ok  = 1'b1;
            end
        end
    end

    // Load attributes come from the latched copy while a response is pending.
    assign ld_type_m = wait_st ? ptype_q : io_ld_type;
    assign ld_off_m  = wait_st ? poff_q  : io_ld_off;
    assign rd_m      = wait_st ? prd_q   : io_in_rd;
    assign wen_m     = wait_st ? pwen_q  : io_in_rf_wen;
    assign sh_amt    = {ld_off_m, 3'b000};
    assign ld_b      = 8'(io_mem_rdata >> sh_amt);
    assign ld_h      = 16'(io_mem_rdata >> sh_amt);
    assign ld_w      = 32'(io_mem_rdata >> sh_amt);

    // Load extraction, extension and alignment/legality check.
    always_comb begin
        ld_data = '0;
        ld_err  = 1'b0;
        case (ld_type_m)
            3'b000: ld_data = XLEN'($signed(ld_b));
            3'b100: ld_data = XLEN'(ld_b);
            3'b001: begin
                ld_err  = ld_off_m[0];
                ld_data = XLEN'($signed(ld_h));
            end
            3'b101: begin
                ld_err  = ld_off_m[0];
                ld_data = XLEN'(ld_h);
            end
            3'b010: begin
                ld_err  = (ld_off_m[1:0] != 2'b00);
                ld_data = XLEN'($signed(ld_w));
            end
            3'b110: begin
                ld_err  = (XLEN != 64) || (ld_off_m[1:0] != 2'b00);
                ld_data = XLEN'(ld_w);
            end
            3'b011: begin
                ld_err  = (XLEN != 64) || (ld_off_m != '0);
                ld_data = io_mem_rdata;
            end
            default: ld_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            prd_q    <= '0;
            pwen_q   <= 1'b0;
            ptype_q  <= '0;
            poff_q   <= '0;
            wen_q    <= 1'b0;
            rd_q     <= '0;
            wd_q     <= '0;
            err_ld_q <= 1'b0;
            err_to_q <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prd_q    <= prd_d;
            pwen_q   <= pwen_d;
            ptype_q  <= ptype_d;
            poff_q   <= poff_d;
            wen_q    <= wen_d;
            rd_q     <= rd_d;
            wd_q     <= wd_d;
            err_ld_q <= err_ld_d;
            err_to_q <= err_to_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

    // Next state and next registered outputs; data arriving wins over timeout.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prd_d    = prd_q;
        pwen_d   = pwen_q;
        ptype_d  = ptype_q;
        poff_d   = poff_q;
        wen_d    = 1'b0;
        rd_d     = rd_q;
        wd_d     = wd_q;
        err_ld_d = 1'b0;
        err_to_d = 1'b0;
        done_ld  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (io_in_valid) begin
                    if (is_mem) begin
                        if (io_mem_valid) begin
                            done_ld = 1'b1;
                        end else begin
                            state_d = S_WAIT;
                            cnt_d   = '0;
                            prd_d   = io_in_rd;
                            pwen_d  = io_in_rf_wen;
                            ptype_d = io_ld_type;
                            poff_d  = io_ld_off;
                        end
                    end else begin
                        rd_d  = io_in_rd;
                        wd_d  = sel_ok ? src_val : '0;
                        wen_d = io_in_rf_wen & sel_ok & (io_in_rd != 5'd0);
                    end
                end
            end
            S_WAIT: begin
                if (io_mem_valid) begin
                    done_ld = 1'b1;
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d  = S_IDLE;
                    cnt_d    = '0;
                    err_to_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
        if (done_ld) begin
            rd_d     = rd_m;
            wd_d     = ld_err ? '0 : ld_data;
            wen_d    = wen_m & ~ld_err & (rd_m != 5'd0);
            err_ld_d = ld_err;
        end
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d == S_WAIT);
    end

endmodule
